// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for a multicycle MIPS-style datapath. One instruction
//   passes through FETCH, DECODE and one to three execution states, then
//   returns to FETCH.
//
// Ports
//   clk       : sole clock, rising-edge active
//   reset     : asynchronous active-high reset
//   op[5:0]   : opcode from the instruction register, valid from DECODE onward
//   zero      : ALU result == 0
//   gtz       : rs value signed > 0
//   pcen, iord, memread, memwrite, irwrite, alusrca, regwrite
//             : datapath enables and selects
//   pcsource, alusrcb, aluop, regdst, memtoreg [1:0]
//             : datapath mux selects and ALU operation class
//   state[3:0]: current state code (debug)
//   retire    : one-cycle pulse in the last state of an instruction
//   illegal   : one-cycle pulse in DECODE for an undefined opcode
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       gtz,
    output logic       pcen,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       alusrca,
    output logic       regwrite,
    output logic [1:0] pcsource,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [3:0] state,
    output logic       retire,
    output logic       illegal
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BGTZ = 6'b100110;
    localparam logic [5:0] OP_NORI = 6'b001101;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JAL    = 4'd11
    } state_t;

    state_t     cur, nxt;
    logic [5:0] opr;   // opcode captured on the edge leaving DECODE

    // Raw enables before the reset gate
    logic pcen_c, memread_c, memwrite_c, irwrite_c, regwrite_c, retire_c, illegal_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= S_FETCH;
            opr <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE)
                opr <= op;
        end
    end

    always_comb begin
        nxt        = S_FETCH;
        pcen_c     = 1'b0;
        iord       = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        alusrca    = 1'b0;
        regwrite_c = 1'b0;
        pcsource   = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        retire_c   = 1'b0;
        illegal_c  = 1'b0;
        case (cur)
            S_FETCH: begin
                nxt       = S_DECODE;
                memread_c = 1'b1;
                irwrite_c = 1'b1;
                pcen_c    = 1'b1;
                alusrcb   = 2'b01;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                // Dispatch uses the live opcode; opr is only loaded on this edge
                case (op)
                    OP_LW, OP_SW:    nxt = S_MEMADR;
                    OP_R:            nxt = S_EXEC;
                    OP_BEQ, OP_BGTZ: nxt = S_BRANCH;
                    OP_NORI:         nxt = S_IEXEC;
                    OP_JAL:          nxt = S_JAL;
                    default: begin
                        nxt       = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                nxt     = (opr == OP_LW) ? S_MEMRD : S_MEMWR;
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                nxt       = S_MEMWB;
                memread_c = 1'b1;
                iord      = 1'b1;
            end
            S_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg   = 2'b01;
                retire_c   = 1'b1;
            end
            S_MEMWR: begin
                memwrite_c = 1'b1;
                iord       = 1'b1;
                retire_c   = 1'b1;
            end
            S_EXEC: begin
                nxt     = S_RWB;
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RWB: begin
                regwrite_c = 1'b1;
                regdst     = 2'b01;
                retire_c   = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsource = 2'b01;
                pcen_c   = ((opr == OP_BEQ) & zero) | ((opr == OP_BGTZ) & gtz);
                retire_c = 1'b1;
            end
            S_IEXEC: begin
                nxt     = S_IWB;
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
            end
            S_IWB: begin
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
            end
            S_JAL: begin
                pcen_c     = 1'b1;
                pcsource   = 2'b10;
                regwrite_c = 1'b1;
                regdst     = 2'b10;
                memtoreg   = 2'b10;
                retire_c   = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // While reset is held the FSM sits in FETCH; its enables must not reach the datapath
    assign pcen     = pcen_c     & ~reset;
    assign memread  = memread_c  & ~reset;
    assign memwrite = memwrite_c & ~reset;
    assign irwrite  = irwrite_c  & ~reset;
    assign regwrite = regwrite_c & ~reset;
    assign retire   = retire_c   & ~reset;
    assign illegal  = illegal_c  & ~reset;
    assign state    = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Scoreboard bench: the stimulus process pushes the expected output vector
//   for every cycle it drives; a monitor pops and compares on each falling edge.
//   Expectations come from the instruction-level state sequence and per-state
//   control table of the multicycle control unit.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BGTZ = 6'b100110;
    localparam logic [5:0] OP_NORI = 6'b001101;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic       zero = 1'b0;
    logic       gtz = 1'b0;
    logic       pcen, iord, memread, memwrite, irwrite, alusrca, regwrite;
    logic [1:0] pcsource, alusrcb, aluop, regdst, memtoreg;
    logic [3:0] state;
    logic       retire, illegal;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .gtz(gtz),
        .pcen(pcen), .iord(iord), .memread(memread), .memwrite(memwrite),
        .irwrite(irwrite), .alusrca(alusrca), .regwrite(regwrite),
        .pcsource(pcsource), .alusrcb(alusrcb), .aluop(aluop),
        .regdst(regdst), .memtoreg(memtoreg), .state(state),
        .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, memread, memwrite, irwrite, alusrca, regwrite;
        logic [1:0] pcsource, alusrcb, aluop, regdst, memtoreg;
        logic       retire, illegal;
    } obs_t;

    obs_t        expq[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    bit          running = 1'b0;

    function automatic bit is_legal(input logic [5:0] o);
        return (o == OP_R) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) ||
               (o == OP_BGTZ) || (o == OP_NORI) || (o == OP_JAL);
    endfunction

    // Number of cycles an instruction occupies, FETCH included
    function automatic int unsigned plen(input logic [5:0] o);
        if (o == OP_LW) return 5;
        if (o == OP_SW || o == OP_R || o == OP_NORI) return 4;
        if (o == OP_BEQ || o == OP_BGTZ || o == OP_JAL) return 3;
        return 2;
    endfunction

    // k-th state code visited by an instruction
    function automatic logic [3:0] pstate(input logic [5:0] o, input int unsigned k);
        logic [3:0] s_lw [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [3:0] s_sw [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        logic [3:0] s_r  [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [3:0] s_ni [4] = '{4'd0, 4'd1, 4'd9, 4'd10};
        if (k < 2) return k[3:0];
        if (o == OP_LW) return s_lw[k];
        if (o == OP_SW) return s_sw[k];
        if (o == OP_R) return s_r[k];
        if (o == OP_NORI) return s_ni[k];
        if (o == OP_JAL) return 4'd11;
        return 4'd8;
    endfunction

    // Control outputs of a state for instruction iop under flags z/g
    function automatic obs_t ctl(input logic [3:0] code, input logic [5:0] iop,
                                 input logic z, input logic g);
        obs_t e = '0;
        e.st = code;
        case (code)
            4'd0:  begin e.memread = 1; e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; end
            4'd1:  begin e.alusrcb = 2'b11; e.illegal = !is_legal(iop); end
            4'd2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            4'd3:  begin e.memread = 1; e.iord = 1; end
            4'd4:  begin e.regwrite = 1; e.memtoreg = 2'b01; e.retire = 1; end
            4'd5:  begin e.memwrite = 1; e.iord = 1; e.retire = 1; end
            4'd6:  begin e.alusrca = 1; e.aluop = 2'b10; end
            4'd7:  begin e.regwrite = 1; e.regdst = 2'b01; e.retire = 1; end
            4'd8:  begin
                e.alusrca = 1; e.aluop = 2'b01; e.pcsource = 2'b01; e.retire = 1;
                e.pcen = ((iop == OP_BEQ) && z) || ((iop == OP_BGTZ) && g);
            end
            4'd9:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b11; end
            4'd10: begin e.regwrite = 1; e.retire = 1; end
            4'd11: begin
                e.pcen = 1; e.pcsource = 2'b10; e.regwrite = 1;
                e.regdst = 2'b10; e.memtoreg = 2'b10; e.retire = 1;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t reset_obs();
        obs_t e = '0;
        e.alusrcb = 2'b01;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] o, input logic z,
                        input logic g, input obs_t e);
        @(posedge clk);
        #1;
        reset = rst;
        op    = o;
        zero  = z;
        gtz   = g;
        expq.push_back(e);
        running = 1'b1;
    endtask

    // Runs one instruction; op is the real opcode only in DECODE and random
    // elsewhere, so later states must rely on the captured opcode.
    task automatic run_instr(input logic [5:0] o, input logic bz, input logic bg);
        for (int unsigned k = 0; k < plen(o); k++) begin
            logic [3:0] code;
            logic [5:0] dop;
            logic       z, g;
            code = pstate(o, k);
            dop  = (k == 1) ? o : 6'($urandom_range(0, 63));
            z    = (code == 4'd8) ? bz : 1'($urandom_range(0, 1));
            g    = (code == 4'd8) ? bg : 1'($urandom_range(0, 1));
            step(1'b0, dop, z, g, ctl(code, o, z, g));
        end
    endtask

    // Monitor: one expected vector per cycle
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (running) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard_underflow: got no expected entry at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    a = '{state, pcen, iord, memread, memwrite, irwrite, alusrca, regwrite,
                          pcsource, alusrcb, aluop, regdst, memtoreg, retire, illegal};
                    chk("cycle_outputs", 32'(a), 32'(e));
                end
            end
        end
    end

    initial begin
        logic [5:0] legal [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BGTZ, OP_NORI, OP_JAL};
        logic [5:0] ro;

        // Held reset: FETCH selects, enables forced low
        step(1'b1, 6'($urandom_range(0, 63)), 1'b0, 1'b0, reset_obs());
        step(1'b1, 6'($urandom_range(0, 63)), 1'b1, 1'b1, reset_obs());

        // Directed cases
        run_instr(OP_LW, 1'b0, 1'b0);
        run_instr(OP_BEQ, 1'b1, 1'b0);
        run_instr(OP_BEQ, 1'b0, 1'b1);
        run_instr(OP_BGTZ, 1'b1, 1'b1);
        run_instr(OP_BGTZ, 1'b1, 1'b0);
        run_instr(OP_JAL, 1'b0, 1'b0);
        run_instr(6'b111111, 1'b0, 1'b0);
        run_instr(OP_SW, 1'b0, 1'b0);
        run_instr(OP_R, 1'b0, 1'b0);
        run_instr(OP_NORI, 1'b0, 1'b0);

        // Reset asserted mid-instruction in MEMRD
        step(1'b0, 6'($urandom_range(0, 63)), 1'b0, 1'b0, ctl(4'd0, OP_LW, 1'b0, 1'b0));
        step(1'b0, OP_LW, 1'b0, 1'b0, ctl(4'd1, OP_LW, 1'b0, 1'b0));
        step(1'b0, 6'($urandom_range(0, 63)), 1'b0, 1'b0, ctl(4'd2, OP_LW, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        op = 6'($urandom_range(0, 63));
        chk("memrd_state", 32'(state), 32'd3);
        chk("memrd_memread", 32'(memread), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_memread", 32'(memread), 32'd0);
        chk("async_reset_irwrite", 32'(irwrite), 32'd0);
        expq.push_back(reset_obs());
        step(1'b1, 6'($urandom_range(0, 63)), 1'b0, 1'b0, reset_obs());
        run_instr(OP_LW, 1'b0, 1'b0);

        // Random instruction stream
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) ro = 6'($urandom_range(0, 63));
            else ro = legal[$urandom_range(0, 6)];
            run_instr(ro, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        running = 1'b0;
        #8;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising-edge active.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port op, input, 6, opcode field from instruction register, valid from DECODE onward.
REQ-004 SHALL have port zero, input, 1, ALU result == 0.
REQ-005 SHALL have port gtz, input, 1, rs value signed > 0.
REQ-006 SHALL have ports pcen, iord, memread, memwrite, irwrite, alusrca, regwrite, each output, 1, datapath enables and selects.
REQ-007 SHALL have ports pcsource, alusrcb, aluop, regdst, memtoreg, each output, 2, datapath mux selects and ALU class.
REQ-008 SHALL have port state, output, 4, current state code for debug.
REQ-009 SHALL have ports retire and illegal, output, 1, one-cycle pulses.

Function
REQ-010 SHALL decode opcodes: R 000000, lw 100011, sw 101011, beq 000100, bgtz 100110, nori 001101, jal 000011; all others illegal.
REQ-011 SHALL implement a Moore FSM with state codes FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, IEXEC 9, IWB 10, JAL 11.
REQ-012 SHALL transition FETCH->DECODE unconditionally and latch op into an internal register on the DECODE clock edge.
REQ-013 SHALL transition from DECODE: lw/sw->MEMADR, R->EXEC, beq/bgtz->BRANCH, nori->IEXEC, jal->JAL, illegal->FETCH.
REQ-014 SHALL transition MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXEC->RWB; IEXEC->IWB; MEMWB, MEMWR, RWB, BRANCH, IWB, JAL->FETCH.
REQ-015 SHALL, in states after DECODE, use the latched opcode, not the live op input.
REQ-016 SHALL, in FETCH, assert memread, irwrite, pcen with iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
REQ-017 SHALL, in DECODE, drive alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
REQ-018 SHALL, in MEMADR, drive alusrca=1, alusrcb=10, aluop=00; in MEMRD assert memread, iord=1; in MEMWR assert memwrite, iord=1.
REQ-019 SHALL, in MEMWB, assert regwrite with regdst=00, memtoreg=01.
REQ-020 SHALL, in EXEC, drive alusrca=1, alusrcb=00, aluop=10; in RWB assert regwrite with regdst=01, memtoreg=00.
REQ-021 SHALL, in IEXEC, drive alusrca=1, alusrcb=10, aluop=11 (NOR with zero-extended imm); in IWB assert regwrite, regdst=00, memtoreg=00.
REQ-022 SHALL, in BRANCH, drive alusrca=1, alusrcb=00, aluop=01, pcsource=01, and pcen = (beq & zero) | (bgtz & gtz), combinationally.
REQ-023 SHALL, in JAL, assert pcen, pcsource=10, regwrite, regdst=10 (register 31), memtoreg=10 (PC).
REQ-024 SHALL deassert every enable not listed for the current state; unlisted selects SHALL be 0.
REQ-025 SHALL pulse retire for one cycle in MEMWB, MEMWR, RWB, BRANCH, IWB, JAL.
REQ-026 SHALL pulse illegal for one cycle in DECODE when op is undefined; retire SHALL stay 0 for that instruction.
REQ-027 SHALL yield latencies: lw 5, R/nori 4, sw 4, beq/bgtz/jal 3 cycles.
REQ-028 SHALL treat a branch with condition false as a normal retire with pcen=0.

Reset
REQ-029 SHALL, on reset assertion, enter FETCH and clear the latched opcode to 0 asynchronously, including mid-instruction.
REQ-030 SHALL, while reset is held, force pcen, memread, memwrite, irwrite, regwrite, retire, illegal to 0.
REQ-031 SHALL, on the first clock after reset release, perform FETCH outputs, then proceed to DECODE.

Verification
REQ-032 SHALL test lw (100011): state 0,1,2,3,4,0; memread in cycles 1 and 4; regwrite with memtoreg=01 in cycle 5; retire in cycle 5.
REQ-033 SHALL test beq with zero=1 and then zero=0: pcen=1 with pcsource=01 in BRANCH, then pcen=0; retire=1 both times.
REQ-034 SHALL test bgtz with gtz=1 and zero=1: pcen=1 in BRANCH; gtz=0: pcen=0.
REQ-035 SHALL test jal (000011): state 0,1,11; pcen, regwrite, regdst=10, memtoreg=10 in cycle 3.
REQ-036 SHALL test op=111111: illegal=1 in DECODE, next state FETCH, no regwrite or memwrite.
REQ-037 SHALL test reset asserted in MEMRD: state=0 immediately with no clock edge, memread=0; after release, FETCH resumes.
